// File: rtl/shift_pipe.sv
// rtl/shift_pipe.sv - DEPTH-stage data/valid shift pipeline with fill counter
// Optional stage tap port enabled by defining SHIFT_PIPE_TAP_EN.
module shift_pipe #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       en,
    input  logic                       flush,
    input  logic [WIDTH-1:0]           d,
    input  logic                       d_vld,
`ifdef SHIFT_PIPE_TAP_EN
    input  logic [$clog2(DEPTH)-1:0]   tap_sel,
    output logic [WIDTH-1:0]           tap_q,
    output logic                       tap_vld,
`endif
    output logic [WIDTH-1:0]           q,
    output logic                       q_vld,
    output logic [$clog2(DEPTH+1)-1:0] fill,
    output logic                       full
);

    localparam int FW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] stage_q [DEPTH];
    logic [DEPTH-1:0] vld_q;
    logic [FW-1:0]    fill_q;
    logic [FW-1:0]    fill_d;

    // Entry in and entry out on the same edge leave the population unchanged.
    always_comb begin
        fill_d = fill_q;
        if (d_vld && !vld_q[DEPTH-1]) begin
            fill_d = fill_q + FW'(1);
        end else if (!d_vld && vld_q[DEPTH-1]) begin
            fill_d = fill_q - FW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                stage_q[i] <= '0;
            end
            vld_q  <= '0;
            fill_q <= '0;
        end else if (flush) begin
            vld_q  <= '0;
            fill_q <= '0;
        end else if (en) begin
            stage_q[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
            vld_q  <= {vld_q[DEPTH-2:0], d_vld};
            fill_q <= fill_d;
        end
    end

    assign q     = stage_q[DEPTH-1];
    assign q_vld = vld_q[DEPTH-1];
    assign fill  = fill_q;
    assign full  = (fill_q == FW'(DEPTH));

`ifdef SHIFT_PIPE_TAP_EN
    localparam int TW = $clog2(DEPTH);

    always_comb begin
        tap_q   = '0;
        tap_vld = 1'b0;
        if ({1'b0, tap_sel} < (TW+1)'(DEPTH)) begin
            tap_q   = stage_q[tap_sel];
            tap_vld = vld_q[tap_sel];
        end
    end
`endif

endmodule

// File: tb/tb_shift_pipe.sv
// tb/tb_shift_pipe.sv - self-checking bench for shift_pipe (WIDTH=8, DEPTH=4)
// Tap checks compile in when SHIFT_PIPE_TAP_EN is defined.
module tb_shift_pipe;

    localparam int W = 8;
    localparam int N = 4;

    logic         clk;
    logic         rst;
    logic         en;
    logic         flush;
    logic [W-1:0] d;
    logic         d_vld;
    logic [W-1:0] q;
    logic         q_vld;
    logic [2:0]   fill;
    logic         full;
`ifdef SHIFT_PIPE_TAP_EN
    logic [1:0]   tap_sel;
    logic [W-1:0] tap_q;
    logic         tap_vld;
`endif

    shift_pipe #(.WIDTH(W), .DEPTH(N)) dut (
        .clk     (clk),
        .rst     (rst),
        .en      (en),
        .flush   (flush),
        .d       (d),
        .d_vld   (d_vld),
`ifdef SHIFT_PIPE_TAP_EN
        .tap_sel (tap_sel),
        .tap_q   (tap_q),
        .tap_vld (tap_vld),
`endif
        .q       (q),
        .q_vld   (q_vld),
        .fill    (fill),
        .full    (full)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int vectors     = 0;
    int miscompares = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after an edge; outputs are sampled at that point too.
    task automatic apply(input logic e, input logic f, input logic [W-1:0] dd, input logic dv);
        en = e; flush = f; d = dd; d_vld = dv;
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
    endtask

    // Reference model: the pipeline as a queue of entries, newest at the front.
    typedef struct {
        logic [W-1:0] data;
        bit           vld;
    } ent_t;
    ent_t pipe[$];

    task automatic m_reset();
        ent_t z;
        z.data = '0;
        z.vld  = 1'b0;
        pipe = {};
        for (int i = 0; i < N; i++) pipe.push_back(z);
    endtask

    task automatic m_edge(input bit e, input bit f, input logic [W-1:0] dd, input bit dv);
        ent_t x;
        if (f) begin
            foreach (pipe[i]) pipe[i].vld = 1'b0;
        end else if (e) begin
            x.data = dd;
            x.vld  = dv;
            pipe.push_front(x);
            void'(pipe.pop_back());
        end
    endtask

    function automatic int m_fill();
        int c = 0;
        foreach (pipe[i]) if (pipe[i].vld) c++;
        return c;
    endfunction

    task automatic m_compare(input string tag);
        int mf;
        mf = m_fill();
        check({tag, "_q"}, 32'(q), 32'(pipe[N-1].data));
        check({tag, "_q_vld"}, 32'(q_vld), 32'(pipe[N-1].vld));
        check({tag, "_fill"}, 32'(fill), 32'(mf));
        check({tag, "_full"}, 32'(full), 32'(mf == N));
    endtask

    typedef struct {
        logic         en;
        logic         flush;
        logic [W-1:0] d;
        logic         dv;
        logic [W-1:0] eq;
        logic         eqv;
        logic [2:0]   efill;
        logic         efull;
    } vec_t;

    vec_t tbl[15];

    initial begin
        tbl[0]  = '{1'b1, 1'b0, 8'h11, 1'b1, 8'h00, 1'b0, 3'd1, 1'b0};
        tbl[1]  = '{1'b1, 1'b0, 8'h22, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[2]  = '{1'b1, 1'b0, 8'h33, 1'b1, 8'h00, 1'b0, 3'd3, 1'b0};
        tbl[3]  = '{1'b1, 1'b0, 8'h44, 1'b1, 8'h11, 1'b1, 3'd4, 1'b1};
        tbl[4]  = '{1'b1, 1'b0, 8'h55, 1'b1, 8'h22, 1'b1, 3'd4, 1'b1};
        tbl[5]  = '{1'b0, 1'b0, 8'h66, 1'b1, 8'h22, 1'b1, 3'd4, 1'b1};
        tbl[6]  = '{1'b0, 1'b1, 8'h77, 1'b1, 8'h22, 1'b0, 3'd0, 1'b0};
        tbl[7]  = '{1'b1, 1'b0, 8'h00, 1'b0, 8'h33, 1'b0, 3'd0, 1'b0};
        tbl[8]  = '{1'b1, 1'b0, 8'hA1, 1'b1, 8'h44, 1'b0, 3'd1, 1'b0};
        tbl[9]  = '{1'b1, 1'b0, 8'hB2, 1'b0, 8'h55, 1'b0, 3'd1, 1'b0};
        tbl[10] = '{1'b1, 1'b0, 8'hC3, 1'b1, 8'h00, 1'b0, 3'd2, 1'b0};
        tbl[11] = '{1'b1, 1'b0, 8'hD4, 1'b0, 8'hA1, 1'b1, 3'd2, 1'b0};
        tbl[12] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hB2, 1'b0, 3'd1, 1'b0};
        tbl[13] = '{1'b1, 1'b0, 8'h00, 1'b0, 8'hC3, 1'b1, 3'd1, 1'b0};
        tbl[14] = '{1'b1, 1'b1, 8'hEE, 1'b1, 8'hC3, 1'b0, 3'd0, 1'b0};

        rst = 1'b0; en = 1'b0; flush = 1'b0; d = '0; d_vld = 1'b0;
`ifdef SHIFT_PIPE_TAP_EN
        tap_sel = '0;
`endif
        #1;
        rst = 1'b1;
        #2;
        check("reset_q", 32'(q), 32'h0);
        check("reset_q_vld", 32'(q_vld), 32'h0);
        check("reset_fill", 32'(fill), 32'h0);
        check("reset_full", 32'(full), 32'h0);
        @(posedge clk);
        #1;
        rst = 1'b0;

        foreach (tbl[i]) begin
            apply(tbl[i].en, tbl[i].flush, tbl[i].d, tbl[i].dv);
            check($sformatf("tbl%0d_q", i), 32'(q), 32'(tbl[i].eq));
            check($sformatf("tbl%0d_q_vld", i), 32'(q_vld), 32'(tbl[i].eqv));
            check($sformatf("tbl%0d_fill", i), 32'(fill), 32'(tbl[i].efill));
            check($sformatf("tbl%0d_full", i), 32'(full), 32'(tbl[i].efull));
        end

        // Stall: A5 reaches q on the 4th enabled edge, fill holds during the stall.
        pulse_reset();
        apply(1'b1, 1'b0, 8'hA5, 1'b1);
        for (int i = 0; i < 3; i++) begin
            apply(1'b0, 1'b0, 8'h00, 1'b0);
            check("stall_fill", 32'(fill), 32'd1);
            check("stall_q_vld", 32'(q_vld), 32'd0);
        end
        for (int i = 2; i <= 4; i++) begin
            apply(1'b1, 1'b0, 8'h00, 1'b0);
            check($sformatf("stall_edge%0d_q_vld", i), 32'(q_vld), 32'(i == 4));
        end
        check("stall_q", 32'(q), 32'hA5);
        check("stall_out_fill", 32'(fill), 32'd1);
        apply(1'b1, 1'b0, 8'h00, 1'b0);
        check("stall_drain_fill", 32'(fill), 32'd0);

        // Flush with en low and d_vld high discards everything.
        pulse_reset();
        for (int i = 1; i <= 3; i++) apply(1'b1, 1'b0, 8'(i), 1'b1);
        check("preflush_fill", 32'(fill), 32'd3);
        apply(1'b0, 1'b1, 8'hFF, 1'b1);
        check("flush_q_vld", 32'(q_vld), 32'd0);
        check("flush_fill", 32'(fill), 32'd0);
        check("flush_full", 32'(full), 32'd0);
        flush = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 8'h00, 1'b0);
            check("postflush_q_vld", 32'(q_vld), 32'd0);
            check("postflush_fill", 32'(fill), 32'd0);
        end

        // Asynchronous reset between edges, then a clean refill.
        pulse_reset();
        apply(1'b1, 1'b0, 8'h5A, 1'b1);
        apply(1'b1, 1'b0, 8'h6B, 1'b1);
        check("prerst_fill", 32'(fill), 32'd2);
        en = 1'b0; d_vld = 1'b0;
        #2;
        rst = 1'b1;
        #1;
        check("arst_q", 32'(q), 32'h0);
        check("arst_q_vld", 32'(q_vld), 32'h0);
        check("arst_fill", 32'(fill), 32'h0);
        check("arst_full", 32'(full), 32'h0);
        rst = 1'b0;
        for (int i = 0; i < 4; i++) begin
            apply(1'b1, 1'b0, 8'(8'h10 + i), 1'b1);
            check("refill_fill", 32'(fill), 32'(i + 1));
        end
        check("refill_q", 32'(q), 32'h10);
        check("refill_q_vld", 32'(q_vld), 32'h1);

`ifdef SHIFT_PIPE_TAP_EN
        pulse_reset();
        for (int i = 1; i <= 4; i++) apply(1'b1, 1'b0, 8'(8'h11 * i), 1'b1);
        en = 1'b0;
        tap_sel = 2'd1;
        #1;
        check("tap1_q", 32'(tap_q), 32'h33);
        check("tap1_vld", 32'(tap_vld), 32'h1);
        tap_sel = 2'd3;
        #1;
        check("tap3_q", 32'(tap_q), 32'h11);
        tap_sel = 2'd0;
        #1;
        check("tap0_q", 32'(tap_q), 32'h44);
        @(posedge clk);
        #1;
`endif

        // Randomised run against the queue model, with occasional async resets.
        pulse_reset();
        m_reset();
        for (int n = 0; n < 400; n++) begin
            logic re, rf, rdv;
            logic [W-1:0] rd;
            if ($urandom_range(0, 49) == 0) begin
                rst = 1'b1;
                #1;
                m_reset();
                m_compare("rnd_arst");
                rst = 1'b0;
            end
            re  = ($urandom_range(0, 3) != 0);
            rf  = ($urandom_range(0, 19) == 0);
            rdv = 1'($urandom_range(0, 1));
            rd  = 8'($urandom);
            apply(re, rf, rd, rdv);
            m_edge(re, rf, rd, rdv);
            m_compare("rnd");
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
